// File: rtl/sar_adc_control_if.sv
// Signal bundle between the SAR conversion controller and its environment.
interface sar_adc_control_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             continuous;
  logic             comp;
  logic             div_load;
  logic [7:0]       div_data;
  logic [WIDTH-1:0] dac_out;
  logic             track;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;

  modport master (
    output start, continuous, comp, div_load, div_data,
    input  dac_out, track, result, valid, busy
  );

  modport slave (
    input  start, continuous, comp, div_load, div_data,
    output dac_out, track, result, valid, busy
  );
endinterface

// File: rtl/sar_adc_control.sv
// Successive-approximation ADC controller: track/hold sequencing, per-bit DAC
// trial with programmable settle time, and comparator decision capture.
module sar_adc_control #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_RESET  = 4
) (
  input logic              clk,
  input logic              rst,
  sar_adc_control_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SAMPLE, TRIAL, SETTLE, DONE} state_t;

  state_t           state, state_next;
  logic [8:0]       cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] sar;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] dac_q;
  logic [7:0]       settle_reg;
  logic [7:0]       settle_len;
  logic [7:0]       settle_pick;
  logic             sync1, comp_s;
  logic             launch;
  logic             settle_end;
  logic             track_q, busy_q, valid_q;

  assign bit_mask    = WIDTH'(1) << bit_idx;
  // A load coinciding with start wins over the stored settle value.
  assign settle_pick = bus.div_load ? bus.div_data : settle_reg;
  // settle_len cycles of DAC settling plus two of synchronizer latency.
  assign settle_end  = (cnt == {1'b0, settle_len} + 9'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    track_q    = 1'b0;
    busy_q     = 1'b1;
    valid_q    = 1'b0;
    dac_q      = sar | bit_mask;
    case (state)
      IDLE: begin
        busy_q = 1'b0;
        dac_q  = result_q;
        if (bus.start || bus.continuous) begin
          state_next = SAMPLE;
          launch     = 1'b1;
        end
      end
      SAMPLE: begin
        track_q = 1'b1;
        dac_q   = '0;
        if (cnt == 9'(SAMPLE_CYCLES - 1)) state_next = TRIAL;
      end
      TRIAL: state_next = SETTLE;
      SETTLE: begin
        if (settle_end) state_next = (bit_idx == '0) ? DONE : TRIAL;
      end
      DONE: begin
        valid_q = 1'b1;
        dac_q   = sar;
        if (bus.continuous) begin
          state_next = SAMPLE;
          launch     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      comp_s     <= 1'b0;
      settle_reg <= 8'(SETTLE_RESET);
      settle_len <= 8'd1;
      cnt        <= '0;
      bit_idx    <= '0;
      sar        <= '0;
      result_q   <= '0;
    end else begin
      sync1  <= bus.comp;
      comp_s <= sync1;
      if (bus.div_load) settle_reg <= bus.div_data;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            settle_len <= (settle_pick == 8'd0) ? 8'd1 : settle_pick;
            cnt        <= '0;
          end
        end
        SAMPLE: begin
          cnt <= cnt + 9'd1;
          if (state_next == TRIAL) begin
            bit_idx <= IW'(WIDTH - 1);
            sar     <= '0;
          end
        end
        TRIAL: cnt <= '0;
        SETTLE: begin
          cnt <= cnt + 9'd1;
          if (settle_end) begin
            if (comp_s) sar <= sar | bit_mask;
            if (bit_idx == '0) result_q <= comp_s ? (sar | bit_mask) : sar;
            else               bit_idx  <= bit_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dac_out = dac_q;
  assign bus.track   = track_q;
  assign bus.result  = result_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_sar_adc_control.sv
// Scoreboard bench for sar_adc_control: stimulus pushes expected code and
// valid cycle; a negedge monitor pops and compares on every valid pulse.
module tb_sar_adc_control;

  localparam int WIDTH = 8;
  localparam int SC    = 4;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  sar_adc_control_if #(.WIDTH(WIDTH)) bus ();

  sar_adc_control #(
    .WIDTH        (WIDTH),
    .SAMPLE_CYCLES(SC),
    .SETTLE_RESET (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Comparator: 0 = analog input 'target', 1 = tied high, 2 = tied low.
  logic [7:0] target;
  int         mode;
  always_comb begin
    case (mode)
      1:       bus.comp = 1'b1;
      2:       bus.comp = 1'b0;
      default: bus.comp = (target >= bus.dac_out);
    endcase
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  res;
    int unsigned cyc;
  } exp_t;
  exp_t sbq[$];

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [7:0]  sreg;
  logic [7:0]  last_res;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Ideal converter: largest code the comparator still reports as <= Vin.
  function automatic logic [7:0] ref_code(input logic [7:0] t, input int m);
    logic [7:0] best = 8'h00;
    for (int c = 0; c < 256; c++) begin
      bit hit = (m == 1) || (m == 0 && int'(t) >= c);
      if (hit) best = 8'(c);
    end
    return best;
  endfunction

  function automatic int unsigned latency(input logic [7:0] s);
    int unsigned se = (s == 8'd0) ? 1 : int'(s);
    return SC + WIDTH * (se + 3) + 1;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.valid) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: result 0x%0h at cycle %0d, want no valid", bus.result, cyc);
        end else begin
          e = sbq.pop_front();
          check("result", bus.result, e.res);
          check("valid_cycle", cyc, e.cyc);
          check("busy_at_valid", bus.busy, 1);
        end
      end
    end
  end

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    bus.div_load = 1'b1;
    bus.div_data = v;
    sreg         = v;
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  task automatic launch(input logic [7:0] t, input int m, input bit ld, input logic [7:0] v,
                        input bit expect_valid);
    @(negedge clk);
    target    = t;
    mode      = m;
    bus.start = 1'b1;
    if (ld) begin
      bus.div_load = 1'b1;
      bus.div_data = v;
      sreg         = v;
    end
    if (expect_valid) begin
      sbq.push_back('{ref_code(t, m), cyc + latency(sreg)});
      last_res = ref_code(t, m);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.div_load = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, sbq.size(), 0);
    @(negedge clk);
    check({name, "_idle_busy"}, bus.busy, 0);
    check({name, "_idle_dac"}, bus.dac_out, last_res);
  endtask

  initial begin
    logic [7:0] v, t;
    int         m;
    bit         ld;
    int unsigned k;

    rst = 1'b1;
    bus.start = 1'b0; bus.continuous = 1'b0; bus.div_load = 1'b0; bus.div_data = 8'd0;
    target = 8'd0; mode = 2; sreg = 8'd4; last_res = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_dac_out", bus.dac_out, 0);
    check("rst_result", bus.result, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_track", bus.track, 0);
    rst = 1'b0;
    sreg = 8'd4;

    load(8'd1);
    launch(8'hA5, 0, 1'b0, 8'd0, 1'b1);
    drain("a5");
    launch(8'h00, 1, 1'b0, 8'd0, 1'b1);
    drain("tied1");
    launch(8'hFF, 2, 1'b0, 8'd0, 1'b1);
    drain("tied0");
    load(8'd0);
    launch(8'h5A, 0, 1'b0, 8'd0, 1'b1);
    drain("settle0");
    launch(8'h33, 0, 1'b1, 8'd3, 1'b1);
    drain("load_with_start");

    // Settle reload mid-conversion only affects the following conversion.
    load(8'd1);
    launch(8'h77, 0, 1'b0, 8'd0, 1'b1);
    repeat (10) @(negedge clk);
    load(8'd10);
    drain("inflight_keep");
    launch(8'h12, 0, 1'b0, 8'd0, 1'b1);
    drain("inflight_next");

    repeat (6) begin
      v  = 8'($urandom_range(0, 5));
      t  = 8'($urandom);
      m  = $urandom_range(0, 2);
      ld = 1'($urandom_range(0, 1));
      launch(t, m, ld, v, 1'b1);
      drain("random");
    end

    // Abort during bit 3 decision window.
    load(8'd1);
    launch(8'hA5, 0, 1'b0, 8'd0, 1'b1);
    drain("pre_abort");
    launch(8'h5C, 0, 1'b0, 8'd0, 1'b0);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_dac_out", bus.dac_out, 0);
    check("abort_result", bus.result, 0);
    check("abort_valid", bus.valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_track", bus.track, 0);
    rst = 1'b0;
    sreg = 8'd4;
    repeat (40) @(negedge clk);
    launch(8'hC3, 0, 1'b0, 8'd0, 1'b1);
    drain("after_abort");

    // Continuous mode with ignored start pulses, then drop continuous.
    load(8'd1);
    @(negedge clk);
    target = 8'h3C;
    mode   = 0;
    bus.continuous = 1'b1;
    k = cyc;
    for (int n = 1; n <= 3; n++) sbq.push_back('{8'h3C, k + 37 * n});
    last_res = 8'h3C;
    while (cyc < k + 15) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < k + 50) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < k + 80) @(negedge clk);
    bus.continuous = 1'b0;
    drain("continuous");
    repeat (50) @(negedge clk);
    check("continuous_stopped_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #(100 * 50000);
    $display("FAIL timeout: simulation exceeded cycle budget at cycle %0d, want completion", cyc);
    $fatal(1);
  end

endmodule
